// File: rtl/pixel_burst_loader_if.sv
// ---------------------------------------------------------------------------
// pixel_burst_loader_if
// Groups the upstream pixel handshake and the chip-side burst outputs of
// pixel_burst_loader into one bundle.
//   master : the upstream source / burst consumer side.
//            Drives start, pix_in and pix_valid.
//            Observes pix_ready, pixel_in0..4, load_end and busy.
//   slave  : the loader itself (the reverse directions).
// Signals:
//   start         one-cycle request to load a new frame
//   pix_in        upstream pixel, row-major order
//   pix_valid     pix_in is valid
//   pix_ready     loader accepts pix_in this cycle
//   pixel_in0..4  burst beat lanes
//   load_end      high on the last burst beat only
//   busy          loader is filling or bursting
// ---------------------------------------------------------------------------
interface pixel_burst_loader_if #(
  parameter int BIT_LENGTH = 5
);
  logic                  start;
  logic [BIT_LENGTH-1:0] pix_in;
  logic                  pix_valid;
  logic                  pix_ready;
  logic [BIT_LENGTH-1:0] pixel_in0;
  logic [BIT_LENGTH-1:0] pixel_in1;
  logic [BIT_LENGTH-1:0] pixel_in2;
  logic [BIT_LENGTH-1:0] pixel_in3;
  logic [BIT_LENGTH-1:0] pixel_in4;
  logic                  load_end;
  logic                  busy;

  modport master (
    output start, pix_in, pix_valid,
    input  pix_ready, pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4,
           load_end, busy
  );

  modport slave (
    input  start, pix_in, pix_valid,
    output pix_ready, pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4,
           load_end, busy
  );
endinterface

// File: rtl/pixel_burst_loader.sv
// ---------------------------------------------------------------------------
// pixel_burst_loader
// Stages one IMG_DIM x IMG_DIM frame, received one pixel per handshake, and
// replays it to the edge-detection chip as an unbroken burst of LANES pixels
// per cycle. Lane j of beat k carries frame pixel LANES*k+j. load_end marks
// the final beat. The chip cannot stall, so nothing pauses the burst.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    pixel_burst_loader_if.slave:
//            start, pix_in, pix_valid in
//            pix_ready, pixel_in0..4, load_end, busy out
// All outputs come straight from registers. The output lanes are wired for
// LANES = 5.
// ---------------------------------------------------------------------------
module pixel_burst_loader #(
  parameter int IMG_DIM    = 20,
  parameter int BIT_LENGTH = 5,
  parameter int LANES      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  pixel_burst_loader_if.slave   bus
);

  localparam int TOTAL  = IMG_DIM * IMG_DIM;
  localparam int NBEATS = TOTAL / LANES;
  localparam int WR_W   = $clog2(TOTAL + 1);
  localparam int BEAT_W = $clog2(NBEATS);
  localparam int IDX_W  = $clog2(TOTAL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t                r_state;
  logic [WR_W-1:0]       r_wr_cnt;
  logic [BEAT_W-1:0]     r_beat;
  logic                  r_pix_ready;
  logic                  r_load_end;
  logic                  r_busy;
  logic [BIT_LENGTH-1:0] r_pix [LANES];
  logic [BIT_LENGTH-1:0] r_buf [TOTAL];

  logic                  w_accept;
  logic                  w_last_accept;
  logic                  w_last_beat;
  logic [BEAT_W-1:0]     w_next_beat;
  logic [IDX_W-1:0]      w_rd_base;
  logic [BIT_LENGTH-1:0] w_rd_pix [LANES];

  // r_pix_ready is only ever high in FILL, so it doubles as the FILL qualifier.
  assign w_accept      = r_pix_ready && bus.pix_valid;
  assign w_last_accept = w_accept && (r_wr_cnt == WR_W'(TOTAL - 1));
  assign w_last_beat   = (r_beat == BEAT_W'(NBEATS - 1));
  assign w_next_beat   = r_beat + BEAT_W'(1);

  // Read address of the beat that will be shown after the next edge: beat 0
  // when leaving FILL, otherwise the beat after the current one. At the
  // final beat the address is parked at 0 so it never leaves the buffer.
  always_comb begin
    w_rd_base = '0;
    if ((r_state == BURST) && !w_last_beat) begin
      w_rd_base = IDX_W'(w_next_beat) * IDX_W'(LANES);
    end
    for (int j = 0; j < LANES; j++) begin
      w_rd_pix[j] = r_buf[w_rd_base + IDX_W'(j)];
    end
  end

  // Frame storage carries no reset; its contents only matter once a full
  // frame has been written.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[IDX_W'(r_wr_cnt)] <= bus.pix_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wr_cnt    <= '0;
      r_beat      <= '0;
      r_pix_ready <= 1'b0;
      r_load_end  <= 1'b0;
      r_busy      <= 1'b0;
      for (int j = 0; j < LANES; j++) begin
        r_pix[j] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state     <= FILL;
            r_wr_cnt    <= '0;
            r_pix_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end

        FILL: begin
          if (w_last_accept) begin
            // Beat 0 is presented in the cycle right after the final accept.
            // Its pixels were all written in earlier cycles.
            r_state     <= BURST;
            r_wr_cnt    <= '0;
            r_pix_ready <= 1'b0;
            r_beat      <= '0;
            r_load_end  <= (NBEATS == 1);
            for (int j = 0; j < LANES; j++) begin
              r_pix[j] <= w_rd_pix[j];
            end
          end else if (w_accept) begin
            r_wr_cnt <= r_wr_cnt + WR_W'(1);
          end
        end

        BURST: begin
          if (w_last_beat) begin
            r_state    <= IDLE;
            r_beat     <= '0;
            r_load_end <= 1'b0;
            r_busy     <= 1'b0;
            for (int j = 0; j < LANES; j++) begin
              r_pix[j] <= '0;
            end
          end else begin
            r_beat     <= w_next_beat;
            r_load_end <= (w_next_beat == BEAT_W'(NBEATS - 1));
            for (int j = 0; j < LANES; j++) begin
              r_pix[j] <= w_rd_pix[j];
            end
          end
        end

        default: begin
          r_state     <= IDLE;
          r_wr_cnt    <= '0;
          r_beat      <= '0;
          r_pix_ready <= 1'b0;
          r_load_end  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pix_ready = r_pix_ready;
  assign bus.load_end  = r_load_end;
  assign bus.busy      = r_busy;
  assign bus.pixel_in0 = r_pix[0];
  assign bus.pixel_in1 = r_pix[1];
  assign bus.pixel_in2 = r_pix[2];
  assign bus.pixel_in3 = r_pix[3];
  assign bus.pixel_in4 = r_pix[4];

endmodule
